// File: rtl/snn_noc_pkg.sv
// Shared definitions for the SNN NoC neuron pipeline: FP constants, the
// weight accumulator state encoding and its default size.
package snn_noc_pkg;

    localparam logic [31:0] FP_ZERO          = 32'h0000_0000;
    localparam int          WACC_NUM_NEURONS = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } wacc_state_t;

endpackage

// File: rtl/weight_accumulator_addsub.sv
// Single-cycle combinational IEEE-754 single-precision adder/subtractor.
// Truncating (no rounding); Exception flags any operand with an all-ones exponent.
module Addition_Subtraction
    import snn_noc_pkg::*;
(
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic        AddBar_Sub,
    output logic        Exception,
    output logic [31:0] result
);

    logic [31:0] w_b_eff;
    logic [31:0] w_big;
    logic [31:0] w_small;
    logic [7:0]  w_e_big;
    logic [7:0]  w_e_small;
    logic [7:0]  w_diff;
    logic [23:0] w_m_big;
    logic [23:0] w_m_small;
    logic [23:0] w_m_shift;
    logic [24:0] w_sum;
    logic [23:0] w_norm;
    logic [8:0]  w_exp;
    logic        w_do_sub;

    always_comb begin
        w_b_eff   = {b_operand[31] ^ AddBar_Sub, b_operand[30:0]};
        // Larger magnitude goes first so the aligned difference never goes negative
        if (b_operand[30:0] > a_operand[30:0]) begin
            w_big   = w_b_eff;
            w_small = a_operand;
        end else begin
            w_big   = a_operand;
            w_small = w_b_eff;
        end
        w_e_big   = (|w_big[30:23])   ? w_big[30:23]   : 8'd1;
        w_e_small = (|w_small[30:23]) ? w_small[30:23] : 8'd1;
        w_m_big   = {|w_big[30:23],   w_big[22:0]};
        w_m_small = {|w_small[30:23], w_small[22:0]};
        w_diff    = w_e_big - w_e_small;
        w_m_shift = w_m_small >> w_diff;
        w_do_sub  = w_big[31] ^ w_small[31];
        w_sum     = w_do_sub ? ({1'b0, w_m_big} - {1'b0, w_m_shift})
                             : ({1'b0, w_m_big} + {1'b0, w_m_shift});
        w_exp     = {1'b0, w_e_big};
        if (w_sum[24]) begin
            w_norm = w_sum[24:1];
            w_exp  = w_exp + 9'd1;
        end else begin
            w_norm = w_sum[23:0];
            for (int unsigned i = 0; i < 23; i++) begin
                if (!w_norm[23] && (w_exp > 9'd1)) begin
                    w_norm = w_norm << 1;
                    w_exp  = w_exp - 9'd1;
                end
            end
        end
        if (w_sum == '0) begin
            result = FP_ZERO;
        end else if (w_exp >= 9'd255) begin
            result = {w_big[31], 8'hFF, 23'h0};
        end else begin
            result = {w_big[31], (w_norm[23] ? w_exp[7:0] : 8'h00), w_norm[22:0]};
        end
    end

    assign Exception = (&a_operand[30:23]) | (&b_operand[30:23]);

endmodule

// File: rtl/weight_accumulator.sv
// Per-timestep synaptic weight integrator with in-order clear-on-read drain.
// Optional sticky FP exception flag: define WEIGHT_ACC_EXCEPTION_FLAG_EN.
module weight_accumulator
    import snn_noc_pkg::*;
#(
    parameter int NUM_NEURONS = WACC_NUM_NEURONS,
    parameter int ID_W        = $clog2(NUM_NEURONS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ID_W-1:0] in_neuron_id,
    input  logic [31:0]     in_weight,
    input  logic            timestep_end,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_neuron_id,
    output logic [31:0]     out_weight,
    output logic            out_last,
    output logic            busy
`ifdef WEIGHT_ACC_EXCEPTION_FLAG_EN
    ,
    output logic            exc_flag
`endif
);

    localparam logic [ID_W:0]   NUM_W   = (ID_W + 1)'(NUM_NEURONS);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_NEURONS - 1);

    wacc_state_t     r_state;
    logic [ID_W-1:0] r_idx;
    logic [31:0]     r_acc [NUM_NEURONS];

    logic            w_accept;
    logic            w_in_range;
    logic [ID_W-1:0] w_rd_id;
    logic [31:0]     w_sum;
    logic            w_exc;
    logic            w_out_hs;

    assign in_ready      = (r_state == ACCUM);
    assign out_valid     = (r_state == DRAIN);
    assign busy          = (r_state == DRAIN);
    assign out_neuron_id = r_idx;
    assign out_weight    = r_acc[r_idx];
    assign out_last      = (r_state == DRAIN) && (r_idx == LAST_ID);

    assign w_accept   = in_valid && in_ready;
    assign w_in_range = ({1'b0, in_neuron_id} < NUM_W);
    assign w_rd_id    = w_in_range ? in_neuron_id : '0;
    assign w_out_hs   = out_valid && out_ready;

    Addition_Subtraction u_addsub (
        .a_operand  (r_acc[w_rd_id]),
        .b_operand  (in_weight),
        .AddBar_Sub (1'b0),
        .Exception  (w_exc),
        .result     (w_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
            r_idx   <= '0;
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                r_acc[i] <= FP_ZERO;
            end
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept && w_in_range) begin
                        r_acc[in_neuron_id] <= w_sum;
                    end
                    if (timestep_end) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_out_hs) begin
                        r_acc[r_idx] <= FP_ZERO;
                        if (r_idx == LAST_ID) begin
                            r_idx   <= '0;
                            r_state <= ACCUM;
                        end else begin
                            r_idx <= r_idx + ID_W'(1);
                        end
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

`ifdef WEIGHT_ACC_EXCEPTION_FLAG_EN
    // Cleared by the first handshake of a drain; events never coincide with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_flag <= 1'b0;
        end else if (w_accept && w_exc) begin
            exc_flag <= 1'b1;
        end else if (w_out_hs && (r_idx == '0)) begin
            exc_flag <= 1'b0;
        end
    end
`else
    logic w_exc_unused;
    assign w_exc_unused = w_exc;
`endif

endmodule
